// File: rtl/core_pkg.sv
// Shared core definitions: ALU operation classes, funct codes and the
// grouped main-control word carried down the pipeline.
package core_pkg;

   localparam logic [1:0] ALUOP_MEM = 2'b00;
   localparam logic [1:0] ALUOP_BR  = 2'b01;
   localparam logic [1:0] ALUOP_R   = 2'b10;

   localparam logic [3:0] F_ADD = 4'b0000;
   localparam logic [3:0] F_SLL = 4'b0001;
   localparam logic [3:0] F_SUB = 4'b1000;
   localparam logic [3:0] F_OR  = 4'b0110;
   localparam logic [3:0] F_AND = 4'b0111;

   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic       branch;
      logic       mem_read;
      logic       mem_write;
      logic       alu_src;
      logic [1:0] alu_op;
      logic [3:0] funct;
   } ctrl_t;

   // Decodes in the EX ALU control as add, so a bubble is side-effect free.
   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_register_if.sv
// ID/EX boundary bundle: decode-side fields (_id) and their registered
// execute-side copies (_ex).
interface id_ex_register_if #(parameter int DATA_W = 64);

   logic              valid_id;
   logic              RegWrite_id, MemtoReg_id, Branch_id;
   logic              MemRead_id, MemWrite_id, ALUSrc_id;
   logic [1:0]        ALUOp_id;
   logic [3:0]        Funct_id;
   logic [DATA_W-1:0] ReadData1_id, ReadData2_id, Imm_id, PC_id;
   logic [4:0]        rs1_id, rs2_id, rd_id;

   logic              valid_ex;
   logic              RegWrite_ex, MemtoReg_ex, Branch_ex;
   logic              MemRead_ex, MemWrite_ex, ALUSrc_ex;
   logic [1:0]        ALUOp_ex;
   logic [3:0]        Funct_ex;
   logic [DATA_W-1:0] ReadData1_ex, ReadData2_ex, Imm_ex, PC_ex;
   logic [4:0]        rs1_ex, rs2_ex, rd_ex;

   modport master (
      output valid_id, RegWrite_id, MemtoReg_id, Branch_id, MemRead_id,
             MemWrite_id, ALUSrc_id, ALUOp_id, Funct_id, ReadData1_id,
             ReadData2_id, Imm_id, PC_id, rs1_id, rs2_id, rd_id,
      input  valid_ex, RegWrite_ex, MemtoReg_ex, Branch_ex, MemRead_ex,
             MemWrite_ex, ALUSrc_ex, ALUOp_ex, Funct_ex, ReadData1_ex,
             ReadData2_ex, Imm_ex, PC_ex, rs1_ex, rs2_ex, rd_ex
   );

   modport slave (
      input  valid_id, RegWrite_id, MemtoReg_id, Branch_id, MemRead_id,
             MemWrite_id, ALUSrc_id, ALUOp_id, Funct_id, ReadData1_id,
             ReadData2_id, Imm_id, PC_id, rs1_id, rs2_id, rd_id,
      output valid_ex, RegWrite_ex, MemtoReg_ex, Branch_ex, MemRead_ex,
             MemWrite_ex, ALUSrc_ex, ALUOp_ex, Funct_ex, ReadData1_ex,
             ReadData2_ex, Imm_ex, PC_ex, rs1_ex, rs2_ex, rd_ex
   );

endinterface

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with hazard stall (hold) and branch flush (bubble).
// Priority: reset > flush > stall > load.
module id_ex_register
   import core_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            flush,
   id_ex_register_if.slave bus
);

   ctrl_t             ctrl_id;
   ctrl_t             ctrl_q;
   logic              valid_q;
   logic [DATA_W-1:0] rd1_q, rd2_q, imm_q, pc_q;
   logic [4:0]        rs1_q, rs2_q, rd_q;

   assign ctrl_id = '{
      reg_write:  bus.RegWrite_id,
      mem_to_reg: bus.MemtoReg_id,
      branch:     bus.Branch_id,
      mem_read:   bus.MemRead_id,
      mem_write:  bus.MemWrite_id,
      alu_src:    bus.ALUSrc_id,
      alu_op:     bus.ALUOp_id,
      funct:      bus.Funct_id
   };

   // Register indices are zeroed in a bubble so forwarding only ever sees x0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_q  <= CTRL_BUBBLE;
         valid_q <= 1'b0;
         rd1_q   <= '0;
         rd2_q   <= '0;
         imm_q   <= '0;
         pc_q    <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
      end else if (flush) begin
         ctrl_q  <= CTRL_BUBBLE;
         valid_q <= 1'b0;
         rd1_q   <= '0;
         rd2_q   <= '0;
         imm_q   <= '0;
         pc_q    <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
      end else if (!stall) begin
         ctrl_q  <= ctrl_id;
         valid_q <= bus.valid_id;
         rd1_q   <= bus.ReadData1_id;
         rd2_q   <= bus.ReadData2_id;
         imm_q   <= bus.Imm_id;
         pc_q    <= bus.PC_id;
         rs1_q   <= bus.rs1_id;
         rs2_q   <= bus.rs2_id;
         rd_q    <= bus.rd_id;
      end
   end

   assign bus.valid_ex     = valid_q;
   assign bus.RegWrite_ex  = ctrl_q.reg_write;
   assign bus.MemtoReg_ex  = ctrl_q.mem_to_reg;
   assign bus.Branch_ex    = ctrl_q.branch;
   assign bus.MemRead_ex   = ctrl_q.mem_read;
   assign bus.MemWrite_ex  = ctrl_q.mem_write;
   assign bus.ALUSrc_ex    = ctrl_q.alu_src;
   assign bus.ALUOp_ex     = ctrl_q.alu_op;
   assign bus.Funct_ex     = ctrl_q.funct;
   assign bus.ReadData1_ex = rd1_q;
   assign bus.ReadData2_ex = rd2_q;
   assign bus.Imm_ex       = imm_q;
   assign bus.PC_ex        = pc_q;
   assign bus.rs1_ex       = rs1_q;
   assign bus.rs2_ex       = rs2_q;
   assign bus.rd_ex        = rd_q;

endmodule
